fios_sequencer: RTL

- Top-level control FSM for one Montgomery multiplication.
- Sequence: operand load (via memory block) → FIOS PE-chain computation → result store.
- Sits between the AXI-lite control/status registers and the memory and FIOS blocks. Drives the memory block's start/load_store inputs and the FIOS start input; consumes their done strobes.
- Adds a per-phase watchdog and a busy-cycle performance counter.

---
 rtl/fios_sequencer_if.sv | 28 ++
 rtl/fios_sequencer.sv | 115 +++++++++++
 2 files changed

// File: rtl/fios_sequencer_if.sv
// fios_sequencer_if: host, memory-block and FIOS-chain handshake bundle around the sequencer
interface fios_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic             clear_i;
    logic             load_done_i;
    logic             store_done_i;
    logic             fios_done_i;
    logic             mem_start_o;
    logic             load_store_o;
    logic             fios_start_o;
    logic             busy_o;
    logic             done_o;
    logic             error_o;
    logic [2:0]       phase_o;
    logic [CNT_W-1:0] cycle_count_o;

    modport slave (
        input  start_i, clear_i, load_done_i, store_done_i, fios_done_i,
        output mem_start_o, load_store_o, fios_start_o, busy_o, done_o, error_o, phase_o, cycle_count_o
    );

    modport master (
        output start_i, clear_i, load_done_i, store_done_i, fios_done_i,
        input  mem_start_o, load_store_o, fios_start_o, busy_o, done_o, error_o, phase_o, cycle_count_o
    );
endinterface

// File: rtl/fios_sequencer.sv
// fios_sequencer: load -> FIOS compute -> store control FSM with per-phase watchdog and busy-cycle counter
module fios_sequencer #(
    parameter int s       = 16,
    parameter int TIMEOUT = 4096,
    parameter int CNT_W   = 32
) (
    input logic             clock_i,
    input logic             reset_i,
    fios_sequencer_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        LOAD_START  = 4'd1,
        LOAD_WAIT   = 4'd2,
        FIOS_START  = 4'd3,
        FIOS_WAIT   = 4'd4,
        STORE_START = 4'd5,
        STORE_WAIT  = 4'd6,
        DONE        = 4'd7,
        ERROR       = 4'd15
    } state_t;

    localparam int PW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    localparam logic [PW-1:0] LIMIT = PW'(TIMEOUT - 1);

    state_t           state;
    logic [PW-1:0]    wait_cnt;
    logic [CNT_W-1:0] cycles;
    logic             in_wait;
    logic             hit;
    logic             expired;

    // ERROR shares readback code 7 with DONE; error_o tells them apart
    assign bus.phase_o       = state[2:0];
    assign bus.cycle_count_o = cycles;

    // A done strobe only counts in the WAIT state it belongs to; the limit is the TIMEOUT-th WAIT cycle
    always_comb begin
        in_wait = state == LOAD_WAIT || state == FIOS_WAIT || state == STORE_WAIT;
        hit     = (state == LOAD_WAIT && bus.load_done_i) || (state == FIOS_WAIT && bus.fios_done_i)
               || (state == STORE_WAIT && bus.store_done_i);
        expired = TIMEOUT != 0 && wait_cnt == LIMIT;
    end

    // Sequencing FSM; every output is a register updated here
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            cycles           <= '0;
            bus.mem_start_o  <= 1'b0;
            bus.load_store_o <= 1'b0;
            bus.fios_start_o <= 1'b0;
            bus.busy_o       <= 1'b0;
            bus.done_o       <= 1'b0;
            bus.error_o      <= 1'b0;
        end else begin
            bus.mem_start_o  <= 1'b0;
            bus.fios_start_o <= 1'b0;
            if (in_wait) wait_cnt <= wait_cnt + PW'(1);
            if (bus.busy_o && cycles != '1) cycles <= cycles + CNT_W'(1);
            case (state)
                IDLE, DONE, ERROR: begin
                    if (bus.start_i) begin
                        state            <= LOAD_START;
                        bus.mem_start_o  <= 1'b1;
                        bus.load_store_o <= 1'b1;
                        bus.busy_o       <= 1'b1;
                        bus.done_o       <= 1'b0;
                        bus.error_o      <= 1'b0;
                        cycles           <= '0;
                    end else if (bus.clear_i) begin
                        state       <= IDLE;
                        bus.done_o  <= 1'b0;
                        bus.error_o <= 1'b0;
                    end
                end
                LOAD_START: begin
                    state    <= LOAD_WAIT;
                    wait_cnt <= '0;
                end
                LOAD_WAIT: if (hit) begin
                    state            <= FIOS_START;
                    bus.fios_start_o <= 1'b1;
                end
                FIOS_START: begin
                    state    <= FIOS_WAIT;
                    wait_cnt <= '0;
                end
                FIOS_WAIT: if (hit) begin
                    state            <= STORE_START;
                    bus.mem_start_o  <= 1'b1;
                    bus.load_store_o <= 1'b0;
                end
                STORE_START: begin
                    state    <= STORE_WAIT;
                    wait_cnt <= '0;
                end
                STORE_WAIT: if (hit) begin
                    state      <= DONE;
                    bus.busy_o <= 1'b0;
                    bus.done_o <= 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (in_wait && !hit && expired) begin
                state            <= ERROR;
                bus.error_o      <= 1'b1;
                bus.busy_o       <= 1'b0;
                bus.done_o       <= 1'b0;
                bus.load_store_o <= 1'b0;
            end
        end
    end
endmodule
